// File: rtl/arm_pkg.sv
// Shared definitions for the ARM front end: fetch FSM encoding, instruction
// width and the bit positions of the decoded instruction fields.
package arm_pkg;

  localparam int INSTR_W = 32;

  localparam int COND_HI  = 31;
  localparam int COND_LO  = 28;
  localparam int OP_HI    = 27;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 25;
  localparam int FUNCT_LO = 20;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with redirect mux and the R15-visible PC+8 value.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic        pc_src,
  input  logic [31:0] result,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Redirect targets are silently word-aligned; increments wrap modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      if (pc_src) begin
        pc_d = result & ~32'h0000_0003;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc       = pc_q;
  assign pc_plus8 = pc_q + 32'd8;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: req/ack fetch FSM, held instruction register and
// field slicing for the control unit; PC state lives in pc_reg.
module fetch_stage
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               advance,
  input  logic               PCSrc,
  input  logic [31:0]        Result,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] Instr,
  output logic [3:0]         Cond,
  output logic [1:0]         Op,
  output logic [5:0]         Funct,
  output logic [3:0]         Rd,
  output logic [31:0]        PC,
  output logic [31:0]        PCPlus8
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               pc_load;

  // Ack is only honoured in FETCH and advance only in HOLD, so stray
  // handshakes in other states cannot disturb the held word or the PC.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pc_load       = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          pc_load       = 1'b1;
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (CLK),
    .rst      (Reset),
    .load_en  (pc_load),
    .pc_src   (PCSrc),
    .result   (Result),
    .pc       (PC),
    .pc_plus8 (PCPlus8)
  );

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = PC[ADDR_W-1:0];
  assign instr_valid = instr_valid_q;
  assign Instr       = instr_q;
  assign Cond        = instr_q[COND_HI:COND_LO];
  assign Op          = instr_q[OP_HI:OP_LO];
  assign Funct       = instr_q[FUNCT_HI:FUNCT_LO];
  assign Rd          = instr_q[RD_HI:RD_LO];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, scoreboarded bench for fetch_stage: expected fetch addresses and
// instruction words are queued when stimulus is driven and popped on output.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        CLK;
  logic        Reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        advance;
  logic        PCSrc;
  logic [31:0] Result;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rd;
  logic [31:0] PC;
  logic [31:0] PCPlus8;

  int vectors;
  int miscompares;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] held_instr;
  logic [31:0] held_pc;

  fetch_stage #(
    .RESET_PC (RST_PC),
    .ADDR_W   (32)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .advance     (advance),
    .PCSrc       (PCSrc),
    .Result      (Result),
    .instr_valid (instr_valid),
    .Instr       (Instr),
    .Cond        (Cond),
    .Op          (Op),
    .Funct       (Funct),
    .Rd          (Rd),
    .PC          (PC),
    .PCPlus8     (PCPlus8)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAddr(input string tag);
    if (exp_addr_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=<empty scoreboard>", tag, imem_addr);
    end else begin
      checkOutput(tag, imem_addr, exp_addr_q.pop_front());
    end
  endtask

  task automatic checkInstr(input string tag);
    if (exp_instr_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=<empty scoreboard>", tag, Instr);
    end else begin
      checkOutput(tag, Instr, exp_instr_q.pop_front());
    end
  endtask

  // From HOLD at a falling edge: advance with a redirect choice, memory acks
  // combinationally, then check the request and the captured word.
  task automatic applyStimulus(input logic src, input logic [31:0] res,
                               input logic [31:0] word, input logic [31:0] exp_pc);
    advance    = 1'b1;
    PCSrc      = src;
    Result     = res;
    imem_ack   = 1'b1;
    imem_rdata = word;
    exp_addr_q.push_back(exp_pc);
    exp_instr_q.push_back(word);
    @(negedge CLK);
    advance = 1'b0;
    PCSrc   = 1'b0;
    Result  = 32'h0;
    checkOutput("adv_req", {31'b0, imem_req}, 32'h1);
    checkOutput("adv_valid_low", {31'b0, instr_valid}, 32'h0);
    checkAddr("adv_addr");
    checkOutput("adv_pc", PC, exp_pc);
    @(negedge CLK);
    imem_ack = 1'b0;
    checkOutput("adv_valid", {31'b0, instr_valid}, 32'h1);
    checkOutput("adv_req_low", {31'b0, imem_req}, 32'h0);
    checkInstr("adv_instr");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    advance     = 1'b0;
    PCSrc       = 1'b0;
    Result      = 32'h0;

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("rst_req", {31'b0, imem_req}, 32'h0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("rst_instr", Instr, 32'h0);
    checkOutput("rst_cond", {28'b0, Cond}, 32'h0);
    checkOutput("rst_rd", {28'b0, Rd}, 32'h0);
    checkOutput("rst_pc", PC, RST_PC);
    checkOutput("rst_pcplus8", PCPlus8, RST_PC + 32'd8);

    // First fetch with ack tied high; the ack seen in IDLE is ignored
    Reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hE591_0004;
    exp_addr_q.push_back(RST_PC);
    exp_instr_q.push_back(32'hE591_0004);
    @(negedge CLK);
    checkOutput("f1_req", {31'b0, imem_req}, 32'h1);
    checkAddr("f1_addr");
    checkOutput("f1_valid_low", {31'b0, instr_valid}, 32'h0);
    @(negedge CLK);
    imem_ack = 1'b0;
    checkOutput("f1_valid", {31'b0, instr_valid}, 32'h1);
    checkOutput("f1_req_low", {31'b0, imem_req}, 32'h0);
    checkInstr("f1_instr");

    // Late ack: request held stable for three cycles before the word arrives
    advance = 1'b1;
    @(negedge CLK);
    advance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("late_req", {31'b0, imem_req}, 32'h1);
      checkOutput("late_addr", imem_addr, RST_PC + 32'd4);
      checkOutput("late_valid_low", {31'b0, instr_valid}, 32'h0);
      @(negedge CLK);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hE3A0_1005;
    exp_instr_q.push_back(32'hE3A0_1005);
    @(negedge CLK);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    checkOutput("late_valid", {31'b0, instr_valid}, 32'h1);
    checkInstr("late_instr");
    checkOutput("late_cond", {28'b0, Cond}, 32'hE);
    checkOutput("late_op", {30'b0, Op}, 32'h0);
    checkOutput("late_funct", {26'b0, Funct}, 32'h3A);
    checkOutput("late_rd", {28'b0, Rd}, 32'h1);

    // Misaligned redirect is aligned, then sequential increment
    applyStimulus(1'b1, 32'h0000_0203, 32'h1111_2222, 32'h0000_0200);
    applyStimulus(1'b0, 32'h0000_0777, 32'h3333_4444, 32'h0000_0204);

    // HOLD with advance low: redirects and stray acks must be ignored
    held_instr = 32'h3333_4444;
    held_pc    = 32'h0000_0204;
    for (int i = 0; i < 5; i++) begin
      PCSrc      = i[0];
      Result     = 32'h0000_0800;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_0000 | i;
      @(negedge CLK);
      checkOutput("hold_instr", Instr, held_instr);
      checkOutput("hold_pc", PC, held_pc);
      checkOutput("hold_valid", {31'b0, instr_valid}, 32'h1);
      checkOutput("hold_req", {31'b0, imem_req}, 32'h0);
    end
    imem_ack = 1'b0;
    PCSrc    = 1'b0;

    // PC wrap at the top of the address space
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h5555_6666, 32'hFFFF_FFFC);
    checkOutput("wrap_pcplus8_top", PCPlus8, 32'h0000_0004);
    applyStimulus(1'b0, 32'h0, 32'h7777_8888, 32'h0000_0000);
    checkOutput("wrap_pcplus8_zero", PCPlus8, 32'h0000_0008);

    // Asynchronous reset in the middle of an outstanding fetch
    advance = 1'b1;
    @(negedge CLK);
    advance = 1'b0;
    checkOutput("mid_req", {31'b0, imem_req}, 32'h1);
    #2 Reset = 1'b1;
    #1;
    checkOutput("async_req", {31'b0, imem_req}, 32'h0);
    checkOutput("async_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("async_pc", PC, RST_PC);
    @(negedge CLK);
    Reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h9999_AAAA;
    exp_addr_q.push_back(RST_PC);
    exp_instr_q.push_back(32'h9999_AAAA);
    @(negedge CLK);
    checkOutput("restart_req", {31'b0, imem_req}, 32'h1);
    checkAddr("restart_addr");
    @(negedge CLK);
    imem_ack = 1'b0;
    checkOutput("restart_valid", {31'b0, instr_valid}, 32'h1);
    checkInstr("restart_instr");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
